ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Parametrised PS/2 host-to-device transmitter that sends one command byte to a keyboard or mouse over the open-drain PS/2 clock/data pair. It sits beside the PS/2 receiver inside the Wishbone PS/2 peripheral, which supplies the byte and observes the status outputs. The transmitter performs the full request-to-send sequence, serialises the frame with odd parity, checks the device ACK, and enforces a watchdog timeout.

## Interface
- CLK_FREQ, 50000000: sys_clk frequency in Hz.
- INHIBIT_US, 100: time ps2_clk is held low before the request, in µs.
- SETUP_CYCLES, 4: cycles that data is low before clock is released (≥1).
- TIMEOUT_US, 15000: maximum time from clock release to frame end, in µs.
- SYNC_STAGES, 2: number of synchroniser flops on ps2_clk_i and ps2_data_i (≥2).

- sys_clk  in  1  single clock; all logic is on the rising edge.
- sys_rst  in  1  reset; asynchronous, active-high.
- tx_data  in  8  command byte; sampled when tx_we is accepted.
- tx_we  in  1  one-cycle write strobe; accepted only in IDLE.
- rx_idle  in  1  1 = the receiver is not mid-frame (its bit count is 0).
- ps2_clk_i  in  1  raw PS/2 clock line.
- ps2_data_i  in  1  raw PS/2 data line.
- ps2_clk_oe  out  1  1 = pull the clock line low.
- ps2_data_oe  out  1  1 = pull the data line low.
- tx_busy  out  1  high from acceptance until the DONE/ERR exit.
- tx_done  out  1  one-cycle pulse on successful ACK.
- tx_err  out  1  one-cycle pulse on failure.
- tx_err_code  out  2  0 none, 1 timeout, 2 no ACK; held until the next accept.

## Operation
- Derived constants:
  - INHIBIT_CYC = CLK_FREQ/1000000*INHIBIT_US.
  - TIMEOUT_CYC = CLK_FREQ/1000000*TIMEOUT_US.
  - Each counter width is $clog2 of its constant plus 1.
- Falling-edge detect on the synchronised clock: fe = sync_clk_d & ~sync_clk.
- IDLE:
  - Both oe outputs are 0.
  - When tx_we is high, latch tx_data and parity = ~^tx_data, clear tx_err_code, and go to WAIT_RX.
- WAIT_RX: when rx_idle = 1, go to INHIBIT.
- INHIBIT:
  - ps2_clk_oe = 1.
  - Count INHIBIT_CYC cycles, then go to REQ.
- REQ:
  - ps2_clk_oe = 1 and ps2_data_oe = 1 (start bit).
  - After SETUP_CYCLES cycles, release the clock, load the watchdog, and go to SEND with bit index 0.
- SEND: on each fe, drive the next bit (ps2_data_oe = ~bit):
  - index 0–7 are data bits, LSB first;
  - index 8 is parity;
  - index 9 is the stop bit (oe = 0);
  - index 10 goes to ACK.
- ACK: on the next fe, sample sync_data.
  - 0: go to WAIT_IDLE.
  - 1: go to ERR with code 2.
- WAIT_IDLE: when sync_clk = 1 and sync_data = 1, go to DONE.
- DONE: pulse tx_done for one cycle, then go to IDLE.
- ERR: release both lines, pulse tx_err for one cycle, then go to IDLE.
- Watchdog:
  - Decrements in SEND, ACK and WAIT_IDLE.
  - Reaching 0 goes to ERR with code 1. This has priority over a simultaneous fe.
- tx_we outside IDLE is ignored; no queueing.
- Reset:
  - All outputs go to 0 immediately and asynchronously, which releases both lines even mid-frame.
  - State goes to IDLE and all counters clear.

## Timing
- Accept to ps2_clk_oe high: 1 cycle if rx_idle = 1.
- ps2_clk_oe stays high for exactly INHIBIT_CYC + SETUP_CYCLES cycles.
- ps2_data_oe rises SETUP_CYCLES cycles before ps2_clk_oe falls.
- fe is seen SYNC_STAGES + 1 cycles after the pin edge.
- Each data change occurs on the cycle after fe is detected, which is well inside the device's clock-low half-period.
- tx_busy:
  - rises the cycle after acceptance;
  - falls in the same cycle as the tx_done/tx_err pulse;
  - IDLE is entered on the following cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package ps2_pkg holds:
  - the state enum (IDLE, WAIT_RX, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR);
  - the error-code constants;
  - the us_to_cycles function.
- Sub-module ps2_line_sync: an SYNC_STAGES synchroniser for clock and data plus the falling-edge pulse. The receiver reuses it.

## Test plan
- Byte 0xED with the device model ACKing: data bits LSB first; parity = 1 (the byte has an even number of ones, 6); stop = 1; tx_done after the ACK; tx_err_code = 0.
- Timing check: ps2_clk_oe is held exactly 5000 + 4 cycles at 50 MHz; ps2_data_oe leads the clock release by 4 cycles.
- Device never clocks: tx_err with code 1 after TIMEOUT_CYC cycles; both oe outputs are 0.
- Device leaves data high at the ACK: tx_err with code 2; no tx_done.
- rx_idle = 0 for 200 cycles after tx_we: ps2_clk_oe stays 0 until rx_idle = 1; a second tx_we while busy is ignored.
- sys_rst asserted at bit 5: both oe outputs drop without waiting for a clock edge; busy = 0; a subsequent byte 0xFF sends correctly with parity = 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and receiver:
// FSM states, error codes and the microsecond-to-cycle conversion.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RX,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NOACK   = 2'd2;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned us);
    return (freq_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake plus PS/2 pin signals of the host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       rx_idle;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] tx_err_code;

  modport master (
    output tx_data, tx_we, rx_idle, ps2_clk_i, ps2_data_i,
    input  ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err, tx_err_code
  );

  modport slave (
    input  tx_data, tx_we, rx_idle, ps2_clk_i, ps2_data_i,
    output ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err, tx_err_code
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Multi-stage synchroniser for the PS/2 clock and data pins with a
// falling-edge pulse on the synchronised clock.
module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_clk_o,
  output logic sync_data_o,
  output logic fe_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_dly_q;

  // Reset to the idle-high line level so no false edge follows reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_dly_q   <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_dly_q   <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_clk_o  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data_o = data_sync_q[SYNC_STAGES-1];
  assign fe_o        = clk_dly_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit odd-parity
// frame, ACK check and watchdog, with registered open-drain enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned INHIBIT_US   = 100,
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned TIMEOUT_US   = 15000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ, TIMEOUT_US);
  localparam int unsigned INH_W   = $clog2(INHIBIT_CYC) + 1;
  localparam int unsigned SETUP_W = $clog2(SETUP_CYCLES) + 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC) + 1;

  ps2_tx_state_e      state_q, state_d;
  logic [INH_W-1:0]   inh_q, inh_d;
  logic [SETUP_W-1:0] setup_q, setup_d;
  logic [TO_W-1:0]    wd_q, wd_d, wd_dec;
  logic [3:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               par_q, par_d;
  logic [1:0]         code_q, code_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               frame_bit;

  logic sync_clk, sync_data, fe;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .ps2_clk_i   (bus.ps2_clk_i),
    .ps2_data_i  (bus.ps2_data_i),
    .sync_clk_o  (sync_clk),
    .sync_data_o (sync_data),
    .fe_o        (fe)
  );

  always_comb begin
    if (bit_q < 4'd8)       frame_bit = data_q[bit_q[2:0]];
    else if (bit_q == 4'd8) frame_bit = par_q;
    else                    frame_bit = 1'b1;
  end

  assign wd_dec = wd_q - TO_W'(1);

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    setup_d   = setup_q;
    wd_d      = wd_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_d     = par_q;
    code_d    = code_q;
    data_oe_d = data_oe_q;

    unique case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (bus.tx_we) begin
          data_d  = bus.tx_data;
          par_d   = ~^bus.tx_data;
          code_d  = ERR_NONE;
          state_d = WAIT_RX;
        end
      end
      WAIT_RX: begin
        inh_d = '0;
        if (bus.rx_idle) state_d = INHIBIT;
      end
      INHIBIT: begin
        if (inh_q == INH_W'(INHIBIT_CYC - 1)) begin
          inh_d     = '0;
          setup_d   = '0;
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          inh_d = inh_q + INH_W'(1);
        end
      end
      REQ: begin
        data_oe_d = 1'b1;
        if (setup_q == SETUP_W'(SETUP_CYCLES - 1)) begin
          setup_d = '0;
          wd_d    = TO_W'(TIMEOUT_CYC);
          bit_d   = '0;
          state_d = SEND;
        end else begin
          setup_d = setup_q + SETUP_W'(1);
        end
      end
      SEND, ACK, WAIT_IDLE: begin
        wd_d = wd_dec;
        // Watchdog expiry wins over a falling edge in the same cycle.
        if (wd_dec == '0) begin
          code_d    = ERR_TIMEOUT;
          data_oe_d = 1'b0;
          state_d   = ERR;
        end else if (state_q == SEND) begin
          if (fe) begin
            if (bit_q == 4'd10) begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end else begin
              data_oe_d = ~frame_bit;
              bit_d     = bit_q + 4'd1;
            end
          end
        end else if (state_q == ACK) begin
          if (fe) begin
            if (!sync_data) begin
              state_d = WAIT_IDLE;
            end else begin
              code_d  = ERR_NOACK;
              state_d = ERR;
            end
          end
        end else begin
          if (sync_clk && sync_data) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
    busy_d   = (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);
    done_d   = (state_d == DONE);
    err_d    = (state_d == ERR);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      inh_q     <= '0;
      setup_q   <= '0;
      wd_q      <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      code_q    <= ERR_NONE;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      setup_q   <= setup_d;
      wd_q      <= wd_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_q     <= par_d;
      code_q    <= code_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
  assign bus.tx_err_code = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, behavioural PS/2 device
// and per-scenario checks against frames computed from the byte value.
module tb_ps2_host_tx;

  localparam int HALF     = 40;
  localparam int INH_CYC  = 5000;
  localparam int SETUP    = 4;
  localparam int TO_CYC   = 20000;

  logic sys_clk;
  logic sys_rst;
  logic dev_clk_low;
  logic dev_data_low;

  int checks = 0;
  int errors = 0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .CLK_FREQ     (50000000),
    .INHIBIT_US   (100),
    .SETUP_CYCLES (4),
    .TIMEOUT_US   (400),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  assign bus.ps2_clk_i  = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_data_i = ~(bus.ps2_data_oe | dev_data_low);

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  initial begin
    #(98000 * 20);
    $display("FAIL global_timeout: simulation exceeded its cycle budget");
    $fatal(1);
  end

  // Passive monitor of line timing and status pulses.
  int cyc = 0;
  int clk_run = 0, lead_run = 0, last_clk_run = 0, last_lead = 0;
  int release_time = 0, err_time = 0;
  int done_cnt = 0, err_cnt = 0, busy_bad = 0;
  logic [1:0] last_err_code = 2'd0;
  logic [1:0] err_oe = 2'd0;

  always @(negedge sys_clk) begin
    if (bus.ps2_clk_oe === 1'b1) begin
      clk_run++;
      if (bus.ps2_data_oe === 1'b1) lead_run++;
    end else begin
      if (clk_run != 0) begin
        last_clk_run = clk_run;
        last_lead    = lead_run;
        release_time = cyc;
      end
      clk_run  = 0;
      lead_run = 0;
    end
    if (bus.tx_done === 1'b1) begin
      done_cnt++;
      if (bus.tx_busy !== 1'b0) busy_bad++;
    end
    if (bus.tx_err === 1'b1) begin
      err_cnt++;
      last_err_code = bus.tx_err_code;
      err_oe        = {bus.ps2_clk_oe, bus.ps2_data_oe};
      err_time      = cyc;
      if (bus.tx_busy !== 1'b0) busy_bad++;
    end
    cyc++;
  end

  // Reference frame: 8 data bits LSB first, odd parity, stop = 1.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge sys_clk);
    bus.tx_data = b;
    bus.tx_we   = 1'b1;
    @(negedge sys_clk);
    bus.tx_we   = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks 12 pulses, samples the host
  // bit on each rising edge, ACKs (data low) before the 12th falling edge.
  task automatic dev_xfer(input bit ack, input int abort_at,
                          output logic [9:0] bits, output bit ok);
    int n = 0;
    bits = '0;
    ok   = 1'b0;
    while (!(bus.ps2_clk_oe === 1'b0 && bus.ps2_data_oe === 1'b1) && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 20000) return;
    ok = 1'b1;
    repeat (HALF) @(negedge sys_clk);
    for (int i = 0; i < 12; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      if (i == abort_at) return;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge sys_clk);
      if (i < 10) bits[i] = bus.ps2_data_i;
      if (i == 10) dev_data_low = ack;
    end
    repeat (HALF) @(negedge sys_clk);
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    checks++;
    if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin
      errors++; $display("FAIL reset_oe: got %b want 00", {bus.ps2_clk_oe, bus.ps2_data_oe});
    end
    checks++;
    if ({bus.tx_busy, bus.tx_done, bus.tx_err} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b want 000", {bus.tx_busy, bus.tx_done, bus.tx_err});
    end
    checks++;
    if (bus.tx_err_code !== 2'd0) begin
      errors++; $display("FAIL reset_code: got %0d want 0", bus.tx_err_code);
    end
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_ed_frame;
    logic [9:0] bits;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_cmd(8'hED);
    dev_xfer(1'b1, 99, bits, ok);
    repeat (100) @(negedge sys_clk);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ed_request: no request-to-send seen"); end
    checks++;
    if (bits !== exp_frame(8'hED)) begin
      errors++; $display("FAIL ed_frame: got %b want %b", bits, exp_frame(8'hED));
    end
    checks++;
    if (bits[8] !== 1'b1) begin errors++; $display("FAIL ed_parity: got %b want 1", bits[8]); end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL ed_done: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (bus.tx_err_code !== 2'd0) begin errors++; $display("FAIL ed_code: got %0d want 0", bus.tx_err_code); end
    checks++;
    if (last_clk_run !== INH_CYC + SETUP) begin
      errors++; $display("FAIL clk_hold: got %0d want %0d", last_clk_run, INH_CYC + SETUP);
    end
    checks++;
    if (last_lead !== SETUP) begin errors++; $display("FAIL data_lead: got %0d want %0d", last_lead, SETUP); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL busy_at_pulse: got %0d want 0", busy_bad); end
  endtask

  task automatic test_timeout;
    int d0 = done_cnt, e0 = err_cnt, n = 0;
    send_cmd(8'h5A);
    while (err_cnt == e0 && n < 30000) begin @(negedge sys_clk); n++; end
    checks++;
    if (err_cnt - e0 !== 1) begin errors++; $display("FAIL to_err: got %0d pulses want 1", err_cnt - e0); end
    checks++;
    if (last_err_code !== 2'd1) begin errors++; $display("FAIL to_code: got %0d want 1", last_err_code); end
    checks++;
    if (err_time - release_time !== TO_CYC) begin
      errors++; $display("FAIL to_cycles: got %0d want %0d", err_time - release_time, TO_CYC);
    end
    checks++;
    if (err_oe !== 2'b00) begin errors++; $display("FAIL to_oe: got %b want 00", err_oe); end
    repeat (20) @(negedge sys_clk);
    checks++;
    if (done_cnt - d0 !== 0) begin errors++; $display("FAIL to_nodone: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_noack;
    logic [9:0] bits;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_cmd(8'h3C);
    dev_xfer(1'b0, 99, bits, ok);
    repeat (100) @(negedge sys_clk);
    checks++;
    if (bits !== exp_frame(8'h3C)) begin
      errors++; $display("FAIL noack_frame: got %b want %b", bits, exp_frame(8'h3C));
    end
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL noack_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (bus.tx_err_code !== 2'd2) begin errors++; $display("FAIL noack_code: got %0d want 2", bus.tx_err_code); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b;
      logic [9:0] bits;
      bit ok, ack;
      int d0 = done_cnt, e0 = err_cnt;
      b   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      send_cmd(b);
      dev_xfer(ack, 99, bits, ok);
      repeat (100) @(negedge sys_clk);
      checks++;
      if (bits !== exp_frame(b)) begin
        errors++; $display("FAIL rand_frame: byte %h got %b want %b", b, bits, exp_frame(b));
      end
      checks++;
      if (done_cnt - d0 !== int'(ack) || err_cnt - e0 !== int'(!ack)) begin
        errors++; $display("FAIL rand_result: ack %0d done %0d err %0d", ack, done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if (bus.tx_err_code !== (ack ? 2'd0 : 2'd2)) begin
        errors++; $display("FAIL rand_code: got %0d want %0d", bus.tx_err_code, ack ? 0 : 2);
      end
    end
  endtask

  task automatic test_rx_idle;
    logic [9:0] bits;
    bit ok;
    int viol = 0, notbusy = 0, d0 = done_cnt;
    bus.rx_idle = 1'b0;
    send_cmd(8'hA7);
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (bus.ps2_clk_oe !== 1'b0) viol++;
      if (bus.tx_busy !== 1'b1) notbusy++;
      if (i == 100) begin
        bus.tx_data = 8'h18;
        bus.tx_we   = 1'b1;
      end else begin
        bus.tx_we = 1'b0;
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL rxidle_hold: clk_oe high %0d cycles want 0", viol); end
    checks++;
    if (notbusy !== 0) begin errors++; $display("FAIL rxidle_busy: not busy %0d cycles want 0", notbusy); end
    bus.rx_idle = 1'b1;
    dev_xfer(1'b1, 99, bits, ok);
    repeat (100) @(negedge sys_clk);
    checks++;
    if (bits !== exp_frame(8'hA7)) begin
      errors++; $display("FAIL rxidle_frame: got %b want %b", bits, exp_frame(8'hA7));
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rxidle_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    bit ok;
    int d0;
    send_cmd(8'h00);
    dev_xfer(1'b1, 5, bits, ok);
    checks++;
    if (bus.ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_pre: data_oe %b want 1", bus.ps2_data_oe); end
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset: oe/busy %b want 000", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_busy});
    end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    d0 = done_cnt;
    send_cmd(8'hFF);
    dev_xfer(1'b1, 99, bits, ok);
    repeat (100) @(negedge sys_clk);
    checks++;
    if (bits !== exp_frame(8'hFF) || bits[8] !== 1'b1) begin
      errors++; $display("FAIL ff_frame: got %b want %b", bits, exp_frame(8'hFF));
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ff_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    sys_rst      = 1'b1;
    bus.tx_we    = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_idle  = 1'b1;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset;
    test_ed_frame;
    test_timeout;
    test_noack;
    test_random;
    test_rx_idle;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
